// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: widths,
// fetch FSM encoding, queue entry layout and the PC increment helper.
package if_stage_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DROP = 2'b10
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Sequential successor address; wraps silently at the top of the space.
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Fetch queue between instruction memory and ID: synchronous enqueue and
// dequeue, flush to empty, occupancy/empty/full status.
module fetch_fifo
   import if_stage_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   enq,
   input  fetch_entry_t           enq_data,
   input  logic                   deq,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   fetch_entry_t     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             do_enq_s;
   logic             do_deq_s;

   assign empty    = (count_r == {(PTR_W + 1){1'b0}});
   assign full     = (count_r == DEPTH_C);
   assign count    = count_r;
   assign head     = mem_r[rd_ptr_r];
   // Overflow/underflow requests are ignored so occupancy stays in 0..DEPTH.
   assign do_enq_s = enq & ~full;
   assign do_deq_s = deq & ~empty;

   // Storage, power-of-two pointers (wrap naturally) and occupancy counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_enq_s) begin
            mem_r[wr_ptr_r] <= enq_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (do_deq_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_enq_s, do_deq_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding memory request FSM feeding a
// small fetch queue, with branch redirect and response dropping.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                QDEPTH   = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               valid,
   output logic [ADDR_W-1:0]  PC,
   output logic [INSTR_W-1:0] instruction
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   fetch_state_t      state_r;
   fetch_state_t      state_next_s;
   logic [ADDR_W-1:0] fetch_pc_r;
   logic [ADDR_W-1:0] fetch_pc_next_s;
   logic [ADDR_W-1:0] req_addr_r;
   logic              req_r;

   logic              enq_s;
   logic              deq_s;
   logic              valid_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              fifo_empty_s;
   logic              fifo_full_s;
   logic [CNT_W-1:0]  occ_after_xfer_s;
   fetch_entry_t      enq_data_s;
   fetch_entry_t      head_s;

   assign valid_s = ~fifo_empty_s;
   assign deq_s   = valid_s & ~freeze & ~branch_taken;
   assign enq_s   = (state_r == BUSY) & imem_ready & ~branch_taken;

   assign enq_data_s.pc    = next_pc(fetch_pc_r);
   assign enq_data_s.instr = imem_rdata;

   // Only evaluated in BUSY, where occupancy < QDEPTH, so +1 cannot overflow.
   assign occ_after_xfer_s = fifo_count_s + CNT_ONE - {{(CNT_W - 1){1'b0}}, deq_s};

   fetch_fifo #(
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (branch_taken),
      .enq      (enq_s),
      .enq_data (enq_data_s),
      .deq      (deq_s),
      .head     (head_s),
      .count    (fifo_count_s),
      .empty    (fifo_empty_s),
      .full     (fifo_full_s)
   );

   // Next-state and next fetch address; a branch overrides everything else.
   always_comb begin
      state_next_s    = state_r;
      fetch_pc_next_s = fetch_pc_r;
      case (state_r)
         IDLE: begin
            if (branch_taken) begin
               fetch_pc_next_s = branch_addr;
               state_next_s    = IDLE;
            end else if (!fifo_full_s || deq_s) begin
               state_next_s = BUSY;
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY: begin
            if (branch_taken) begin
               fetch_pc_next_s = branch_addr;
               state_next_s    = imem_ready ? IDLE : DROP;
            end else if (imem_ready) begin
               fetch_pc_next_s = next_pc(fetch_pc_r);
               state_next_s    = (occ_after_xfer_s < QDEPTH_C) ? BUSY : IDLE;
            end else begin
               state_next_s = BUSY;
            end
         end
         DROP: begin
            if (branch_taken) begin
               fetch_pc_next_s = branch_addr;
            end else begin
               fetch_pc_next_s = fetch_pc_r;
            end
            // The abandoned request completes here regardless of a new branch.
            state_next_s = imem_ready ? IDLE : DROP;
         end
         default: begin
            state_next_s    = IDLE;
            fetch_pc_next_s = fetch_pc_r;
         end
      endcase
   end

   // FSM state, fetch address and registered memory-request outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         fetch_pc_r <= RESET_PC;
         req_addr_r <= RESET_PC;
         req_r      <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         fetch_pc_r <= fetch_pc_next_s;
         // DROP keeps presenting the abandoned address until its response.
         if (state_next_s == DROP) begin
            req_addr_r <= req_addr_r;
         end else begin
            req_addr_r <= fetch_pc_next_s;
         end
         req_r <= (state_next_s == BUSY) || (state_next_s == DROP);
      end
   end

   assign imem_req    = req_r;
   assign imem_addr   = req_addr_r;
   assign valid       = valid_s;
   assign PC          = valid_s ? head_s.pc    : {ADDR_W{1'b0}};
   assign instruction = valid_s ? head_s.instr : {INSTR_W{1'b0}};

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter QDEPTH, default 2, fetch-queue depth in entries; legal values are 2 and 4.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 freeze  input  1  hazard stall from ID; blocks dequeue.
REQ-006 branch_taken  input  1  redirect request from EXE.
REQ-007 branch_addr  input  32  redirect target, word aligned.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  request address.
REQ-010 imem_ready  input  1  response strobe; imem_rdata is valid in this cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 valid  output  1  queue head holds an instruction for ID.
REQ-013 PC  output  32  head instruction address + 4.
REQ-014 instruction  output  32  head instruction word.

Function
REQ-015 The memory protocol SHALL allow one outstanding request; imem_req and imem_addr are held stable from assertion until the cycle imem_ready=1.
REQ-016 The FSM SHALL have the states IDLE, BUSY and DROP; imem_req=1 exactly in BUSY or DROP; imem_addr=fetch_pc register.
REQ-017 IDLE->BUSY SHALL occur when occupancy-minus-dequeue < QDEPTH and branch_taken=0.
REQ-018 BUSY with imem_ready=1 and branch_taken=0 SHALL enqueue {fetch_pc+4, imem_rdata} and set fetch_pc+=4; it stays BUSY if post-update occupancy < QDEPTH, else goes to IDLE.
REQ-019 Dequeue SHALL occur when valid=1, freeze=0 and branch_taken=0.
REQ-020 Enqueue and dequeue in the same cycle SHALL leave occupancy unchanged; an enqueue into an empty queue SHALL be visible at the outputs the next cycle (fetch latency = memory latency + 1).
REQ-021 branch_taken=1 SHALL take priority over freeze, enqueue and dequeue: it empties the queue, loads fetch_pc<=branch_addr, and drops any imem_rdata returned in that cycle.
REQ-022 A branch in BUSY with imem_ready=0 SHALL go to DROP, keeping imem_addr at the old address.
REQ-023 A branch in BUSY with imem_ready=1, or in IDLE, SHALL go to IDLE.
REQ-024 DROP SHALL discard the response on imem_ready=1 and go to IDLE; a branch while in DROP SHALL update fetch_pc and stay in DROP.
REQ-025 Queue pointers SHALL wrap modulo QDEPTH; occupancy never exceeds QDEPTH and never goes below 0.
REQ-026 When valid=0, PC and instruction SHALL be 0.
REQ-027 fetch_pc+4 SHALL wrap modulo 2^32 with no flag.

Reset
REQ-028 While rst=1, the block SHALL be in state IDLE, with fetch_pc=RESET_PC, the queue empty, valid=0, imem_req=0, PC=0 and instruction=0.
REQ-029 Reset asserted mid-request SHALL abandon the request; the memory tolerates this.
REQ-030 The first imem_req SHALL rise in the second cycle after rst deasserts.

Structure
REQ-031 The state encoding and the instruction and address width constants SHALL reside in the shared pipeline package.
REQ-032 The queue SHALL be one sub-module, fetch_fifo, providing synchronous enqueue/dequeue, a flush input and count/empty/full outputs; the FSM and fetch_pc remain in if_stage.

Verification
REQ-033 Zero-wait memory (imem_ready=1 whenever imem_req=1), freeze=0 -> instruction words at 0,4,8,12 appear with PC=4,8,12,16 on consecutive cycles after the first.
REQ-034 freeze held for 5 cycles with QDEPTH=2 -> the queue fills to 2, imem_req drops, and the head stays PC=8 for the whole freeze; the stream resumes with no loss or duplicate.
REQ-035 branch_taken with branch_addr=32'h100 while a 3-cycle-latency request to 32'h8 is outstanding -> DROP; the 32'h8 data is never output; the next valid shows PC=32'h104.
REQ-036 branch_taken and freeze asserted together with the queue full -> the queue empties, valid=0 the next cycle, and fetch restarts at branch_addr.
REQ-037 rst pulsed while BUSY -> all outputs at their reset values within the same cycle; fetch restarts at RESET_PC.
REQ-038 A branch to 32'hFFFF_FFFC -> the head shows PC=32'h0000_0000 (wrap).
